trap_ctrl: RTL

- Machine-mode trap sequencer for the pipelined RV32I core. Sits beside the EX stage.
- Detects synchronous exceptions (illegal instruction, ecall), mret and enabled interrupts on the instruction in EX.
- On a take: stalls and flushes the pipeline, then drives the single CSR write port over several cycles to update mepc/mcause/mstatus, then redirects the PC.
- Arbitrates that CSR write port between itself and the pipeline's Zicsr instructions.

---
 rtl/trap_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: detects exceptions, mret and enabled interrupts in EX,
// then drives the shared CSR write port across several cycles before redirecting the PC.
module trap_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter bit          MTVEC_VEC_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_illegal,
  input  logic            ex_ecall,
  input  logic            ex_mret,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic [XLEN-1:0] csr_mstatus,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  input  logic            pipe_csr_we,
  output logic            pipe_csr_grant,
  output logic            trap_csr_we,
  output logic [11:0]     trap_csr_addr,
  output logic [XLEN-1:0] trap_csr_wdata,
  output logic            stall,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  localparam logic [11:0]     AddrMstatus = 12'h300;
  localparam logic [11:0]     AddrMepc    = 12'h341;
  localparam logic [11:0]     AddrMcause  = 12'h342;
  localparam logic [XLEN-1:0] CauseIll    = XLEN'(2);
  localparam logic [XLEN-1:0] CauseEcall  = XLEN'(11);
  localparam logic [XLEN-1:0] CauseExt    = {1'b1, (XLEN-1)'(11)};
  localparam logic [XLEN-1:0] CauseTimer  = {1'b1, (XLEN-1)'(7)};

  typedef enum logic [2:0] {
    StIdle, StWMepc, StWMcause, StWMstatus, StTRedirect, StMMstatus, StMRedirect
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;

  logic            mie, irq_pend, take, is_mret;
  logic [XLEN-1:0] cause_sel, trap_ms, mret_ms, base;

  always_comb begin
    mie      = csr_mstatus[3];
    irq_pend = mie & (irq_ext | irq_timer);
    take     = (state_q == StIdle) & ex_valid &
               (ex_illegal | ex_ecall | ex_mret | irq_pend);
    is_mret  = ex_mret & ~ex_illegal & ~ex_ecall;

    if (ex_illegal)         cause_sel = CauseIll;
    else if (ex_ecall)      cause_sel = CauseEcall;
    else if (irq_ext & mie) cause_sel = CauseExt;
    else                    cause_sel = CauseTimer;

    trap_ms        = csr_mstatus;
    trap_ms[7]     = csr_mstatus[3];
    trap_ms[3]     = 1'b0;
    trap_ms[12:11] = 2'b11;

    mret_ms        = csr_mstatus;
    mret_ms[3]     = csr_mstatus[7];
    mret_ms[7]     = 1'b1;
    mret_ms[12:11] = 2'b11;

    base = csr_mtvec & ~XLEN'(3);
  end

  always_comb begin
    state_d        = state_q;
    epc_d          = epc_q;
    cause_d        = cause_q;
    pipe_csr_grant = 1'b0;
    trap_csr_we    = 1'b0;
    trap_csr_addr  = 12'h000;
    trap_csr_wdata = '0;
    stall          = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    busy           = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        stall          = take;
        flush          = take;
        pipe_csr_grant = pipe_csr_we & ~take;
        if (take) begin
          epc_d = ex_pc;
          if (is_mret) begin
            state_d = StMMstatus;
          end else begin
            cause_d = cause_sel;
            state_d = StWMepc;
          end
        end
      end
      StWMepc: begin
        stall          = 1'b1;
        flush          = 1'b1;
        trap_csr_we    = 1'b1;
        trap_csr_addr  = AddrMepc;
        trap_csr_wdata = epc_q;
        state_d        = StWMcause;
      end
      StWMcause: begin
        stall          = 1'b1;
        flush          = 1'b1;
        trap_csr_we    = 1'b1;
        trap_csr_addr  = AddrMcause;
        trap_csr_wdata = cause_q;
        state_d        = StWMstatus;
      end
      StWMstatus: begin
        stall          = 1'b1;
        flush          = 1'b1;
        trap_csr_we    = 1'b1;
        trap_csr_addr  = AddrMstatus;
        trap_csr_wdata = trap_ms;
        state_d        = StTRedirect;
      end
      StTRedirect: begin
        stall          = 1'b1;
        flush          = 1'b1;
        redirect_valid = 1'b1;
        // Vectoring applies to interrupts only, and only for mtvec mode 01.
        if (MTVEC_VEC_EN && cause_q[XLEN-1] && (csr_mtvec[1:0] == 2'b01)) begin
          redirect_pc = base + (XLEN'(cause_q[4:0]) << 2);
        end else begin
          redirect_pc = base;
        end
        state_d = StIdle;
      end
      StMMstatus: begin
        stall          = 1'b1;
        flush          = 1'b1;
        trap_csr_we    = 1'b1;
        trap_csr_addr  = AddrMstatus;
        trap_csr_wdata = mret_ms;
        state_d        = StMRedirect;
      end
      StMRedirect: begin
        stall          = 1'b1;
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = csr_mepc;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

endmodule
